// File: rtl/rf_tagged_if.sv
// rf_tagged_if: bundle of the register file's issue, write-back, flush and
// read-port signals.
//   master modport: the pipeline side (decode/issue, commit) that drives
//                   issue/wb/flush/read requests and receives read results.
//   slave modport : the register file itself.
// Handshake: none. Every input is sampled on every rising edge once ready = 1;
// read results are combinational from rd_en/rd_addr and the stored state.
interface rf_tagged_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 4,
  parameter int RD_PORTS = 2
);
  logic                         ready;
  logic                         issue_en;
  logic [ADDR_W-1:0]            issue_addr;
  logic [TAG_W-1:0]             issue_tag;
  logic                         wb_en;
  logic [ADDR_W-1:0]            wb_addr;
  logic [TAG_W-1:0]             wb_tag;
  logic [DATA_W-1:0]            wb_data;
  logic                         flush;
  logic [RD_PORTS-1:0]          rd_en;
  logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
  logic [RD_PORTS*DATA_W-1:0]   rd_data;
  logic [RD_PORTS-1:0]          rd_busy;
  logic [RD_PORTS*TAG_W-1:0]    rd_tag;

  modport master (
    output issue_en, issue_addr, issue_tag,
    output wb_en, wb_addr, wb_tag, wb_data,
    output flush, rd_en, rd_addr,
    input  ready, rd_data, rd_busy, rd_tag
  );

  modport slave (
    input  issue_en, issue_addr, issue_tag,
    input  wb_en, wb_addr, wb_tag, wb_data,
    input  flush, rd_en, rd_addr,
    output ready, rd_data, rd_busy, rd_tag
  );
endinterface

// File: rtl/rf_tagged.sv
// rf_tagged: architectural register file with per-register rename state
// (busy bit + producer tag). Register 0 is hardwired to zero / not busy.
// After reset an INIT sweep zeroes registers 1..NUM_REGS-1, then RUN.
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-low reset
//   bus       rf_tagged_if.slave: issue, write-back, flush, read ports, ready
//   dbg_state current FSM state (0 = INIT, 1 = RUN)
// Optional feature: define RF_WB_BYPASS_EN to forward a same-cycle write-back
// to matching read ports (data, and busy clear when the tag matches).
module rf_tagged #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 4,
  parameter int RD_PORTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  rf_tagged_if.slave  bus,
  output logic        dbg_state
);
  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                ready_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [TAG_W-1:0]    tags [NUM_REGS];

  logic issue_ok;
  logic wb_ok;
  logic wb_clear;

  assign issue_ok = bus.issue_en && (bus.issue_addr != '0);
  assign wb_ok    = bus.wb_en && (bus.wb_addr != '0);
  assign wb_clear = wb_ok && busy[bus.wb_addr] && (tags[bus.wb_addr] == bus.wb_tag);

  assign bus.ready = ready_q;
  assign dbg_state = state;

  // Init sweep FSM; ready is registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INIT;
      cnt     <= {{(ADDR_W-1){1'b0}}, 1'b1};
      ready_q <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data array has no reset; the sweep clears it. Entry 0 is never read.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      regs[cnt] <= '0;
    end else if (wb_ok) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Rename state. Flush dominates everything; otherwise the issue update is
  // applied after the write-back clear so a same-address issue wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
    end else if (state == S_RUN) begin
      if (bus.flush) begin
        busy <= '0;
      end else begin
        if (wb_clear) busy[bus.wb_addr] <= 1'b0;
        if (issue_ok) begin
          busy[bus.issue_addr] <= 1'b1;
          tags[bus.issue_addr] <= bus.issue_tag;
        end
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              act;
    logic              fwd;

    assign a   = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign act = ready_q && bus.rd_en[p] && (a != '0);
`ifdef RF_WB_BYPASS_EN
    assign fwd = bus.wb_en && (bus.wb_addr == a);
`else
    assign fwd = 1'b0;
`endif
    assign bus.rd_data[p*DATA_W +: DATA_W] = !act ? '0 : (fwd ? bus.wb_data : regs[a]);
    assign bus.rd_busy[p] = act && busy[a] && !(fwd && (tags[a] == bus.wb_tag));
    assign bus.rd_tag[p*TAG_W +: TAG_W] = act ? tags[a] : '0;
  end
endmodule
